subword_sbox_pipe: RTL and testbench

Pipelined 32-bit SubWord / InvSubWord unit built on composite-field GF(((2^2)^2)^2) S-box arithmetic. Four byte lanes are processed in parallel through a 3-stage pipeline with valid/ready flow control. The unit sits between the key-expansion word generator (RotWord output) and the round-key XOR. It is also reusable as a SubBytes column engine. Each lane consumes the GF(2^4) square-times-lambda and GF(2^4) inverse/multiply primitives.

---
 rtl/subword_sbox_pipe_if.sv | 22 ++
 rtl/subword_sbox_pipe.sv | 160 ++++++++++++++++
 tb/tb_subword_sbox_pipe.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/subword_sbox_pipe_if.sv
// Word stream bus shared by the key-expansion word generator, the S-box pipe
// and the round-key XOR stage.
interface subword_sbox_pipe_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_word;
  logic        in_inv;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic        out_inv;

  modport master (
    output in_valid, in_word, in_inv, out_ready,
    input  in_ready, out_valid, out_word, out_inv
  );

  modport slave (
    input  in_valid, in_word, in_inv, out_ready,
    output in_ready, out_valid, out_word, out_inv
  );
endinterface

// File: rtl/subword_sbox_pipe.sv
// Four-lane SubWord / InvSubWord pipe using GF(((2^2)^2)^2) tower-field inversion,
// with an input capture register ahead of the three arithmetic stages.
module subword_sbox_pipe (
  input  logic               clk,
  input  logic               rst,
  subword_sbox_pipe_if.slave bus
);

  localparam logic [3:0] LAMBDA = 4'b1100;

  function automatic logic [1:0] gf4_mul(input logic [1:0] a, input logic [1:0] b);
    gf4_mul = {(a[1] & b[1]) ^ (a[1] & b[0]) ^ (a[0] & b[1]),
               (a[1] & b[1]) ^ (a[0] & b[0])};
  endfunction

  function automatic logic [1:0] gf4_mul_phi(input logic [1:0] a);
    gf4_mul_phi = {a[1] ^ a[0], a[1]};
  endfunction

  function automatic logic [3:0] gf16_mul(input logic [3:0] a, input logic [3:0] b);
    logic [1:0] hh;
    hh = gf4_mul(a[3:2], b[3:2]);
    gf16_mul = {hh ^ gf4_mul(a[3:2], b[1:0]) ^ gf4_mul(a[1:0], b[3:2]),
                gf4_mul_phi(hh) ^ gf4_mul(a[1:0], b[1:0])};
  endfunction

  // a^14 = a^-1 in GF(2^4); zero stays zero, which gives the S-box 0 -> 0 rule.
  function automatic logic [3:0] gf16_inv(input logic [3:0] a);
    logic [3:0] a2, a4, a8;
    a2 = gf16_mul(a, a);
    a4 = gf16_mul(a2, a2);
    a8 = gf16_mul(a4, a4);
    gf16_inv = gf16_mul(gf16_mul(a8, a4), a2);
  endfunction

  function automatic logic [7:0] iso_map(input logic [7:0] q);
    iso_map = {q[7] ^ q[5],
               q[7] ^ q[6] ^ q[4] ^ q[3] ^ q[2] ^ q[1],
               q[7] ^ q[5] ^ q[3] ^ q[2],
               q[7] ^ q[5] ^ q[3] ^ q[2] ^ q[1],
               q[7] ^ q[6] ^ q[2] ^ q[1],
               q[7] ^ q[4] ^ q[3] ^ q[2] ^ q[1],
               q[6] ^ q[4] ^ q[1],
               q[6] ^ q[1] ^ q[0]};
  endfunction

  function automatic logic [7:0] iso_inv(input logic [7:0] q);
    iso_inv = {q[7] ^ q[6] ^ q[5] ^ q[1],
               q[6] ^ q[2],
               q[6] ^ q[5] ^ q[1],
               q[6] ^ q[5] ^ q[4] ^ q[2] ^ q[1],
               q[5] ^ q[4] ^ q[3] ^ q[2] ^ q[1],
               q[7] ^ q[4] ^ q[3] ^ q[2] ^ q[1],
               q[5] ^ q[4],
               q[6] ^ q[5] ^ q[4] ^ q[2] ^ q[0]};
  endfunction

  function automatic logic [7:0] affine_fwd(input logic [7:0] b);
    affine_fwd = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
               ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] affine_inv(input logic [7:0] s);
    affine_inv = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
  endfunction

  // Returns {hi, lo, d} for one lane.
  function automatic logic [11:0] s1_lane(input logic [7:0] b, input logic inv);
    logic [7:0] m;
    logic [3:0] hi, lo;
    m  = iso_map(inv ? affine_inv(b) : b);
    hi = m[7:4];
    lo = m[3:0];
    s1_lane = {hi, lo, gf16_mul(gf16_mul(hi, hi), LAMBDA) ^ gf16_mul(hi, lo)
                       ^ gf16_mul(lo, lo)};
  endfunction

  function automatic logic [7:0] s3_lane(input logic [3:0] hi, input logic [3:0] lo,
                                         input logic [3:0] dinv, input logic inv);
    logic [7:0] b;
    b = iso_inv({gf16_mul(hi, dinv), gf16_mul(hi ^ lo, dinv)});
    s3_lane = inv ? b : affine_fwd(b);
  endfunction

  logic stall;

  logic            vld_p0_q, inv_p0_q;
  logic [3:0][7:0] word_p0_q;
  logic            vld_p1_q, inv_p1_q;
  logic [3:0][3:0] hi_p1_q, lo_p1_q, d_p1_q;
  logic            vld_p2_q, inv_p2_q;
  logic [3:0][3:0] hi_p2_q, lo_p2_q, dinv_p2_q;
  logic            vld_p3_q, inv_p3_q;
  logic [3:0][7:0] word_p3_q;

  logic [3:0][3:0] hi_p1_d, lo_p1_d, d_p1_d, dinv_p2_d;
  logic [3:0][7:0] word_p3_d;

  assign stall        = vld_p3_q & ~bus.out_ready;
  assign bus.in_ready = ~stall;
  assign bus.out_valid = vld_p3_q;
  assign bus.out_inv   = inv_p3_q;
  assign bus.out_word  = word_p3_q;

  always_comb begin
    hi_p1_d   = '0;
    lo_p1_d   = '0;
    d_p1_d    = '0;
    dinv_p2_d = '0;
    word_p3_d = '0;
    for (int l = 0; l < 4; l++) begin
      {hi_p1_d[l], lo_p1_d[l], d_p1_d[l]} = s1_lane(word_p0_q[l], inv_p0_q);
      dinv_p2_d[l] = gf16_inv(d_p1_q[l]);
      word_p3_d[l] = s3_lane(hi_p2_q[l], lo_p2_q[l], dinv_p2_q[l], inv_p2_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0_q  <= 1'b0;
      inv_p0_q  <= 1'b0;
      word_p0_q <= '0;
      vld_p1_q  <= 1'b0;
      inv_p1_q  <= 1'b0;
      hi_p1_q   <= '0;
      lo_p1_q   <= '0;
      d_p1_q    <= '0;
      vld_p2_q  <= 1'b0;
      inv_p2_q  <= 1'b0;
      hi_p2_q   <= '0;
      lo_p2_q   <= '0;
      dinv_p2_q <= '0;
      vld_p3_q  <= 1'b0;
      inv_p3_q  <= 1'b0;
      word_p3_q <= '0;
    end else if (!stall) begin
      // p0: capture the accepted word
      vld_p0_q  <= bus.in_valid & bus.in_ready;
      inv_p0_q  <= bus.in_inv;
      word_p0_q <= bus.in_word;
      // p1: pre-transform, isomorphic map, norm d
      vld_p1_q  <= vld_p0_q;
      inv_p1_q  <= inv_p0_q;
      hi_p1_q   <= hi_p1_d;
      lo_p1_q   <= lo_p1_d;
      d_p1_q    <= d_p1_d;
      // p2: GF(2^4) inverse of d
      vld_p2_q  <= vld_p1_q;
      inv_p2_q  <= inv_p1_q;
      hi_p2_q   <= hi_p1_q;
      lo_p2_q   <= lo_p1_q;
      dinv_p2_q <= dinv_p2_d;
      // p3: recombine, inverse map, forward affine
      vld_p3_q  <= vld_p2_q;
      inv_p3_q  <= inv_p2_q;
      word_p3_q <= word_p3_d;
    end
  end

endmodule

// File: tb/tb_subword_sbox_pipe.sv
// Bench for subword_sbox_pipe: directed FIPS-197 vectors plus randomized traffic
// scored against a table model built from plain GF(2^8) arithmetic.
module tb_subword_sbox_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  subword_sbox_pipe_if bus ();

  subword_sbox_pipe dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [7:0] sbox  [256];
  logic [7:0] isbox [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  task automatic build_tables();
    logic [7:0] c, iv, s;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      iv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) iv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = iv[i] ^ iv[(i + 4) % 8] ^ iv[(i + 5) % 8] ^ iv[(i + 6) % 8]
             ^ iv[(i + 7) % 8] ^ c[i];
      sbox[x]  = s;
      isbox[s] = 8'(x);
    end
  endtask

  function automatic logic [31:0] model_word(input logic [31:0] w, input logic inv);
    logic [31:0] r;
    for (int k = 0; k < 4; k++)
      r[8*k +: 8] = inv ? isbox[w[8*k +: 8]] : sbox[w[8*k +: 8]];
    return r;
  endfunction

  // Scoreboard: expected {inv, word} pushed on each accepted input.
  logic [32:0] exp_q[$];
  int          cyc = 0;
  int          n_out = 0;
  int          first_out = 0;
  int          last_out = 0;

  initial begin : monitor
    logic        stall_prev;
    logic [32:0] held, e;
    stall_prev = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        exp_q.delete();
        stall_prev = 1'b0;
      end else begin
        check_eq("in_ready", 64'(bus.in_ready), 64'(!(bus.out_valid && !bus.out_ready)));
        if (stall_prev)
          check_eq("hold", 64'({bus.out_inv, bus.out_word}), 64'(held));
        if (bus.out_valid && bus.out_ready) begin
          if (n_out == 0) first_out = cyc;
          last_out = cyc;
          n_out++;
          if (exp_q.size() == 0) begin
            check_eq("extra_out", 64'(bus.out_valid), 64'(0));
          end else begin
            e = exp_q.pop_front();
            check_eq("out_word", 64'(bus.out_word), 64'(e[31:0]));
            check_eq("out_inv", 64'(bus.out_inv), 64'(e[32]));
          end
        end
        if (bus.in_valid && bus.in_ready)
          exp_q.push_back({bus.in_inv, model_word(bus.in_word, bus.in_inv)});
        stall_prev = bus.out_valid && !bus.out_ready;
        held = {bus.out_inv, bus.out_word};
      end
    end
  end

  task automatic drain(input string tag);
    int n;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq(tag, 64'(exp_q.size()), 64'(0));
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic single(input string tag, input logic [31:0] w, input logic inv,
                        output logic [31:0] got, output logic got_inv);
    int lat;
    repeat (4) @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.in_word  = w;
    bus.in_inv   = inv;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq({tag, "_lat"}, 64'(lat), 64'(3));
    got     = bus.out_word;
    got_inv = bus.out_inv;
  endtask

  initial begin : main
    logic [31:0] got, w, f;
    logic        gi;
    int          sent;

    build_tables();
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_word   = '0;
    bus.in_inv    = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    check_eq("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check_eq("rst_out_word", 64'(bus.out_word), 64'(0));
    check_eq("rst_out_inv", 64'(bus.out_inv), 64'(0));
    check_eq("rst_in_ready", 64'(bus.in_ready), 64'(1));

    single("fwd", 32'h000153FF, 1'b0, got, gi);
    check_eq("fwd_word", 64'(got), 64'(32'h637CED16));
    check_eq("fwd_inv", 64'(gi), 64'(0));
    single("inv", 32'h637CED16, 1'b1, got, gi);
    check_eq("inv_word", 64'(got), 64'(32'h000153FF));
    check_eq("inv_inv", 64'(gi), 64'(1));
    single("key", 32'hCF4F3C09, 1'b0, got, gi);
    check_eq("key_word", 64'(got), 64'(32'h8A84EB01));

    for (int i = 0; i < 6; i++) begin
      w = $urandom;
      single("rt_fwd", w, 1'b0, f, gi);
      single("rt_inv", f, 1'b1, got, gi);
      check_eq("roundtrip", 64'(got), 64'(w));
    end

    // Exhaustive stream, one word per cycle, mode alternating.
    drain("pre_stream_drain");
    n_out = 0;
    for (int i = 0; i < 256; i++) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.in_word  = {8'(i + 3), 8'(i + 2), 8'(i + 1), 8'(i)};
      bus.in_inv   = i[0];
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    drain("stream_drain");
    check_eq("stream_cnt", 64'(n_out), 64'(256));
    check_eq("stream_span", 64'(last_out - first_out), 64'(255));

    // Backpressure: five back-to-back words, sink stalled for cycles 4..9.
    n_out = 0;
    sent  = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      bus.out_ready = !(c >= 4 && c <= 9);
      bus.in_valid  = (sent < 5);
      bus.in_word   = $urandom;
      bus.in_inv    = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) sent++;
    end
    drain("bp_drain");
    check_eq("bp_sent", 64'(sent), 64'(5));
    check_eq("bp_cnt", 64'(n_out), 64'(5));

    // Random traffic with random backpressure.
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      bus.in_valid  = ($urandom_range(0, 9) < 7);
      bus.out_ready = ($urandom_range(0, 9) < 7);
      bus.in_word   = $urandom;
      bus.in_inv    = 1'($urandom_range(0, 1));
    end
    drain("rand_drain");

    // Reset with three words in flight.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.in_word  = $urandom | 32'h01010101;
      bus.in_inv   = 1'b0;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("mid_rst_valid", 64'(bus.out_valid), 64'(0));
    check_eq("mid_rst_word", 64'(bus.out_word), 64'(0));
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check_eq("mid_rst_stale", 64'(bus.out_valid), 64'(0));
    end
    single("post_rst", 32'hCF4F3C09, 1'b0, got, gi);
    check_eq("post_rst_word", 64'(got), 64'(32'h8A84EB01));
    drain("final_drain");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
